// File: rtl/stage5_message_dispatch.sv
// Stage-5 message dispatch: packs stage-4 messages into three-lane batches tagged by a type table.
// Optional statistics counters are built when STAGE5_DISPATCH_STATS_EN is defined.
module stage5_message_dispatch #(
  parameter int MSG_W         = 512,
  parameter int CTRL_W        = 4,
  parameter int TYPE_W        = 8,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MSG_W-1:0]  in_msg,
  input  logic [TYPE_W-1:0] in_type,
  input  logic              in_last,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [TYPE_W-1:0] cfg_type,
  input  logic [CTRL_W-1:0] cfg_code,
  input  logic              cfg_clr,
  output logic              message_en,
  output logic [MSG_W-1:0]  message_1,
  output logic [MSG_W-1:0]  message_2,
  output logic [MSG_W-1:0]  message_3,
  output logic [CTRL_W-1:0] message_mux_control_m1,
  output logic [CTRL_W-1:0] message_mux_control_m2,
  output logic [CTRL_W-1:0] message_mux_control_m3,
  input  logic              out_ready,
  output logic [15:0]       stat_batches,
  output logic [15:0]       stat_unmatched
);

  typedef enum logic [1:0] {IDLE, FILL, ISSUE} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(FLUSH_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [1:0]        fill, fill_nxt;
  logic [7:0]        timer, timer_nxt;
  logic              live;
  logic              xfer;
  logic              accept;

  logic [3:0]        tbl_valid;
  logic [TYPE_W-1:0] tbl_type [4];
  logic [CTRL_W-1:0] tbl_code [4];
  logic [3:0]        match_vec;
  logic [CTRL_W-1:0] lookup_code;

  logic [MSG_W-1:0]  lane_msg  [3];
  logic [CTRL_W-1:0] lane_code [3];

  assign xfer   = in_valid & in_ready;
  assign accept = (state == ISSUE) & out_ready;

  // live holds in_ready low until the first clock edge after reset is released.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  assign in_ready   = live & (state != ISSUE);
  assign message_en = (state == ISSUE);

  // NOTE: only the valid bits are reset; type/code storage is don't-care while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
    end else if (cfg_clr) begin
      tbl_valid <= '0;
    end else if (cfg_we) begin
      tbl_valid[cfg_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && !cfg_clr) begin
      tbl_type[cfg_addr] <= cfg_type;
      tbl_code[cfg_addr] <= cfg_code;
    end
  end

  // Descending scan so the lowest-index matching entry is the one left standing.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    lookup_code = '0;
    for (int i = 0; i < 4; i++) begin
      match_vec[i] = tbl_valid[i] && (tbl_type[i] == in_type);
    end
    for (int i = 3; i >= 0; i--) begin
      if (match_vec[i]) lookup_code = tbl_code[i];
    end
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (xfer) begin
          fill_nxt  = 2'd1;
          timer_nxt = '0;
          state_nxt = in_last ? ISSUE : FILL;
        end
      end
      FILL: begin
        if (xfer) begin
          fill_nxt  = fill + 2'd1;
          timer_nxt = '0;
          if (fill == 2'd2 || in_last) state_nxt = ISSUE;
        end else if (timer == TIMER_LAST) begin
          state_nxt = ISSUE;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          fill_nxt  = '0;
          timer_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        fill_nxt  = '0;
        timer_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fill  <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      fill  <= fill_nxt;
      timer <= timer_nxt;
    end
  end

  // Lanes drive the outputs directly, so they are reset to give zero outputs during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        lane_msg[i]  <= '0;
        lane_code[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        lane_msg[i]  <= '0;
        lane_code[i] <= '0;
      end
    end else if (xfer) begin
      lane_msg[fill]  <= in_msg;
      lane_code[fill] <= lookup_code;
    end
  end

  assign message_1              = lane_msg[0];
  assign message_2              = lane_msg[1];
  assign message_3              = lane_msg[2];
  assign message_mux_control_m1 = lane_code[0];
  assign message_mux_control_m2 = lane_code[1];
  assign message_mux_control_m3 = lane_code[2];

`ifdef STAGE5_DISPATCH_STATS_EN
  logic [15:0] batch_cnt;
  logic [15:0] unmatched_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batch_cnt     <= '0;
      unmatched_cnt <= '0;
    end else if (cfg_clr) begin
      batch_cnt     <= '0;
      unmatched_cnt <= '0;
    end else begin
      if (accept && batch_cnt != 16'hFFFF) batch_cnt <= batch_cnt + 16'd1;
      if (xfer && match_vec == 4'b0 && unmatched_cnt != 16'hFFFF)
        unmatched_cnt <= unmatched_cnt + 16'd1;
    end
  end

  assign stat_batches   = batch_cnt;
  assign stat_unmatched = unmatched_cnt;
`else
  assign stat_batches   = '0;
  assign stat_unmatched = '0;
`endif

endmodule
